// File: rtl/ysyx_23060221_axi_sram.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_axi_sram
//
// AXI4 slave memory placed directly behind the core's io_master port. It
// holds a word-addressed SRAM and serves one transaction at a time. It
// supports single-beat and burst (FIXED / INCR / WRAP) reads and writes, and
// it can add a programmable read latency so that bench timing can stress
// the master's handshakes.
//
// Parameters
//   BASE        byte address of array word 0
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   RD_DELAY    idle cycles between AR acceptance and the first R beat (0-15)
//
// Ports
//   clock, reset (async, active-low)
//   AW: awready/awvalid/awaddr/awid/awlen/awsize/awburst
//   W : wready/wvalid/wdata/wstrb/wlast
//   B : bready/bvalid/bresp/bid
//   AR: arready/arvalid/araddr/arid/arlen/arsize/arburst
//   R : rready/rvalid/rresp/rdata/rlast/rid
// ---------------------------------------------------------------------------
module ysyx_23060221_axi_sram #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_DELAY   = 0
) (
    input  logic        clock,
    input  logic        reset,

    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,

    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,

    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,

    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,

    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]  DLY_INIT  = 4'((RD_DELAY == 0) ? 0 : RD_DELAY - 1);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        up_q;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  dly_q, dly_d;
    logic        werr_q, werr_d;
    logic        mem_we;

    logic [31:0] mem [DEPTH];

    // Per-beat decode of the current address and the latched burst fields.
    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  addr_ok;
    logic                  wrap_len_ok;
    logic                  beat_err;
    logic                  last_beat;

    assign offset      = addr_q - BASE;   // wraps for addresses below BASE
    assign addr_ok     = (offset >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign widx        = offset[DEPTH_LOG2+1:2];
    assign wrap_len_ok = (len_q == 8'd1) || (len_q == 8'd3) ||
                         (len_q == 8'd7) || (len_q == 8'd15);
    assign beat_err    = !addr_ok || (size_q > 3'd2) || (burst_q == 2'b11) ||
                         ((burst_q == 2'b10) && !wrap_len_ok);
    assign last_beat   = (beat_q == len_q);

    // Next beat address. The WRAP window is (len+1)<<size bytes; for legal
    // lengths that is a power of two, so wrapping is a mask on the low bits.
    logic [31:0] step;
    logic [31:0] wrap_mask;
    logic [31:0] addr_nxt;

    assign step      = 32'd1 << size_q;
    assign wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;

    always_comb begin
        addr_nxt = addr_q;
        case (burst_q)
            2'b01:   addr_nxt = addr_q + step;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: addr_nxt = addr_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
            addr_q  <= 32'd0;
            id_q    <= 4'd0;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            dly_q   <= 4'd0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= 1'b1;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            dly_q   <= dly_d;
            werr_q  <= werr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        beat_d  = beat_q;
        size_d  = size_q;
        burst_d = burst_q;
        dly_d   = dly_q;
        werr_d  = werr_q;
        mem_we  = 1'b0;

        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = RESP_OKAY;
        bid     = 4'd0;
        rvalid  = 1'b0;
        rresp   = RESP_OKAY;
        rdata   = 32'd0;
        rlast   = 1'b0;
        rid     = 4'd0;

        case (state_q)
            IDLE: begin
                arready = up_q;
                // Reads win when both address channels are valid.
                awready = up_q && !arvalid;
                if (up_q && arvalid) begin
                    addr_d  = araddr;
                    id_d    = arid;
                    len_d   = arlen;
                    size_d  = arsize;
                    burst_d = arburst;
                    beat_d  = 8'd0;
                    if (RD_DELAY > 0) begin
                        dly_d   = DLY_INIT;
                        state_d = RD_WAIT;
                    end else begin
                        state_d = RD_DATA;
                    end
                end else if (up_q && awvalid) begin
                    addr_d  = awaddr;
                    id_d    = awid;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    beat_d  = 8'd0;
                    werr_d  = 1'b0;
                    state_d = WR_DATA;
                end
            end

            RD_WAIT: begin
                if (dly_q == 4'd0) begin
                    state_d = RD_DATA;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end

            RD_DATA: begin
                rvalid = 1'b1;
                rid    = id_q;
                rlast  = last_beat;
                rresp  = beat_err ? RESP_SLV : RESP_OKAY;
                rdata  = beat_err ? 32'd0 : mem[widx];
                if (rready) begin
                    addr_d = addr_nxt;
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end

            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = !beat_err;
                    addr_d = addr_nxt;
                    beat_d = beat_q + 8'd1;
                    // A wlast that disagrees with the beat count poisons the response.
                    if (beat_err || (wlast != last_beat)) begin
                        werr_d = 1'b1;
                    end
                    if (wlast || last_beat) begin
                        state_d = WR_RESP;
                    end
                end
            end

            WR_RESP: begin
                bvalid = 1'b1;
                bid    = id_q;
                bresp  = werr_q ? RESP_SLV : RESP_OKAY;
                if (bready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Storage array: byte-lane writes, contents intentionally not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
